// File: rtl/osc_playback_engine_if.sv
// Mixed-sample handshake between the playback engine and the audio output stage.
// The engine drives data/valid (master); the consumer drives ready (slave).
interface osc_playback_engine_if #(
  parameter int SAMPLE_WIDTH = 16
) ();
  logic signed [SAMPLE_WIDTH-1:0] mix_data_out;
  logic                           mix_valid_out;
  logic                           mix_ready_in;

  modport master (output mix_data_out, output mix_valid_out, input mix_ready_in);
  modport slave  (input mix_data_out, input mix_valid_out, output mix_ready_in);
endinterface

// File: rtl/osc_playback_engine.sv
// Wavetable playback: one phase step per oscillator per sample tick, BRAM readback,
// saturating mix, and valid/ready presentation of one mixed sample per period.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | waiting for the sample tick
// S_ADVANCE | drive BRAM indices from current phases, step phases
// S_WAIT    | BRAM read latency
// S_ACCUM   | sum returned samples of enabled oscillators
// S_SAT     | clamp sum into mix_data_out, raise valid
// S_PRESENT | hold sample until consumer accepts; ticks here are overruns
module osc_playback_engine #(
  parameter int NUM_OSCILLATORS = 4,
  parameter int SAMPLE_WIDTH    = 16,
  parameter int WW_WIDTH        = 18,
  parameter int PHASE_FRAC      = 12,
  parameter int SAMPLE_PERIOD   = 2268,
  parameter int BRAM_LATENCY    = 2
) (
  input  logic                             clk_in,
  input  logic                             rst_n_in,
  input  logic [WW_WIDTH-1:0]              wave_width_in,
  input  logic [NUM_OSCILLATORS-1:0]       osc_is_on_in,
  input  logic [WW_WIDTH+PHASE_FRAC-1:0]   osc_step_in   [NUM_OSCILLATORS],
  output logic [WW_WIDTH-1:0]              osc_index_out [NUM_OSCILLATORS],
  input  logic signed [SAMPLE_WIDTH-1:0]   osc_data_in   [NUM_OSCILLATORS],
  osc_playback_engine_if.master            mix_if,
  output logic [7:0]                       overrun_count_out
);

  localparam int PW    = WW_WIDTH + PHASE_FRAC;
  localparam int SUM_W = SAMPLE_WIDTH + $clog2(NUM_OSCILLATORS);
  localparam int TW    = $clog2(SAMPLE_PERIOD);
  localparam int WC_W  = $clog2(BRAM_LATENCY + 1);

  localparam logic signed [SUM_W-1:0] SAT_MAX =
    {{(SUM_W-SAMPLE_WIDTH+1){1'b0}}, {(SAMPLE_WIDTH-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] SAT_MIN =
    {{(SUM_W-SAMPLE_WIDTH+1){1'b1}}, {(SAMPLE_WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE, S_ADVANCE, S_WAIT, S_ACCUM, S_SAT, S_PRESENT
  } state_t;

  state_t                      state;
  logic [TW-1:0]               tick_cnt;
  logic                        tick;
  logic [WC_W-1:0]             wait_cnt;
  logic [PW-1:0]               phase     [NUM_OSCILLATORS];
  logic [PW-1:0]               phase_nxt [NUM_OSCILLATORS];
  logic [NUM_OSCILLATORS-1:0]  en_q;
  logic signed [SUM_W-1:0]     acc;
  logic signed [SUM_W-1:0]     acc_q;
  logic signed [SAMPLE_WIDTH-1:0] sat;
  logic                        width_zero;
  logic [PW:0]                 wrap_span;

  assign tick       = (tick_cnt == TW'(SAMPLE_PERIOD - 1));
  assign width_zero = (wave_width_in == '0);
  assign wrap_span  = {1'b0, wave_width_in, {PHASE_FRAC{1'b0}}};

  // The sum keeps its carry bit so a step near the top of the range still wraps correctly.
  always_comb begin
    for (int i = 0; i < NUM_OSCILLATORS; i++) begin
      logic [PW:0] s;
      s = {1'b0, phase[i]} + {1'b0, osc_step_in[i]};
      if (s[PW:PHASE_FRAC] >= {1'b0, wave_width_in}) s = s - wrap_span;
      if (s[PW:PHASE_FRAC] >= {1'b0, wave_width_in}) s = '0;
      phase_nxt[i] = s[PW-1:0];
    end
  end

  always_comb begin
    acc = '0;
    for (int i = 0; i < NUM_OSCILLATORS; i++) begin
      if (en_q[i]) acc = acc + SUM_W'(osc_data_in[i]);
    end
  end

  always_comb begin
    if (acc_q > SAT_MAX)      sat = SAT_MAX[SAMPLE_WIDTH-1:0];
    else if (acc_q < SAT_MIN) sat = SAT_MIN[SAMPLE_WIDTH-1:0];
    else                      sat = acc_q[SAMPLE_WIDTH-1:0];
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state                <= S_IDLE;
      tick_cnt             <= '0;
      wait_cnt             <= '0;
      en_q                 <= '0;
      acc_q                <= '0;
      mix_if.mix_data_out  <= '0;
      mix_if.mix_valid_out <= 1'b0;
      overrun_count_out    <= '0;
      for (int i = 0; i < NUM_OSCILLATORS; i++) begin
        phase[i]         <= '0;
        osc_index_out[i] <= '0;
      end
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
      case (state)
        S_IDLE: if (tick) state <= S_ADVANCE;
        S_ADVANCE: begin
          for (int i = 0; i < NUM_OSCILLATORS; i++) begin
            if (!osc_is_on_in[i] || width_zero) begin
              phase[i]         <= '0;
              osc_index_out[i] <= '0;
            end else begin
              osc_index_out[i] <= phase[i][PW-1:PHASE_FRAC];
              phase[i]         <= phase_nxt[i];
            end
          end
          en_q     <= width_zero ? '0 : osc_is_on_in;
          wait_cnt <= WC_W'(BRAM_LATENCY - 1);
          state    <= S_WAIT;
        end
        S_WAIT: begin
          if (wait_cnt == '0) state <= S_ACCUM;
          else                wait_cnt <= wait_cnt - WC_W'(1);
        end
        S_ACCUM: begin
          acc_q <= acc;
          state <= S_SAT;
        end
        S_SAT: begin
          mix_if.mix_data_out  <= sat;
          mix_if.mix_valid_out <= 1'b1;
          state                <= S_PRESENT;
        end
        S_PRESENT: begin
          // A tick here is dropped: the pending sample wins over a new phase step.
          if (tick && overrun_count_out != 8'hFF)
            overrun_count_out <= overrun_count_out + 8'd1;
          if (mix_if.mix_ready_in) begin
            mix_if.mix_valid_out <= 1'b0;
            state                <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
